miter_cmp_monitor: RTL

- Parametrised, clocked successor to the per-net equivalence miter: compares NUM_CH gold/gate output channels of WIDTH bits each, cycle by cycle, for emulation/simulation sign-off of post-CTS jpeg_encoder partitions.
- Masks undefined gold bits with an explicit per-bit define mask, which replaces the X-tolerant compare.
- Counts comparisons and mismatches, and latches the first failure: channel, cycle and data.
- Sits beside the gold and gate instances of a partition miter and drives a sticky pass/fail flag.

---
 rtl/miter_pkg.sv | 21 ++
 rtl/miter_cmp_monitor_if.sv | 47 ++++
 rtl/miter_sat_counter.sv | 43 ++++
 rtl/miter_cmp_monitor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/miter_pkg.sv
// Shared definitions for the clocked gold/gate miter monitor.
//   state_e    : monitor state machine encoding
//   chan_idx_w : width of a channel index (never less than 1 bit)
//   CNT_W_DEF  : default width of the saturating counters
package miter_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FAIL   = 2'd3
  } state_e;

  // A single channel still needs a 1-bit index port.
  function automatic int chan_idx_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/miter_cmp_monitor_if.sv
// Bundle between a partition miter (gold/gate instances) and its monitor.
//   master : drives en, clear, ch_valid, gold_data, gate_data, gold_def;
//            observes the result signals
//   slave  : the monitor; samples the compare inputs and drives
//            mismatch, fail, fail_ch, fail_cycle, fail_gold, fail_gate,
//            cmp_cnt, mis_cnt, busy
// Channel c occupies bits [c*WIDTH +: WIDTH] of every packed data vector.
interface miter_cmp_monitor_if
  import miter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) ();

  localparam int IDX_W = chan_idx_w(NUM_CH);

  logic                    en;
  logic                    clear;
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH*WIDTH-1:0] gold_data;
  logic [NUM_CH*WIDTH-1:0] gate_data;
  logic [NUM_CH*WIDTH-1:0] gold_def;

  logic                    mismatch;
  logic                    fail;
  logic [IDX_W-1:0]        fail_ch;
  logic [CNT_W-1:0]        fail_cycle;
  logic [WIDTH-1:0]        fail_gold;
  logic [WIDTH-1:0]        fail_gate;
  logic [CNT_W-1:0]        cmp_cnt;
  logic [CNT_W-1:0]        mis_cnt;
  logic                    busy;

  modport master (
    output en, clear, ch_valid, gold_data, gate_data, gold_def,
    input  mismatch, fail, fail_ch, fail_cycle, fail_gold, fail_gate,
           cmp_cnt, mis_cnt, busy
  );

  modport slave (
    input  en, clear, ch_valid, gold_data, gate_data, gold_def,
    output mismatch, fail, fail_ch, fail_cycle, fail_gold, fail_gate,
           cmp_cnt, mis_cnt, busy
  );

endinterface

// File: rtl/miter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : synchronous clear to zero
//   inc_i      : amount added this cycle (INC_W bits)
//   cnt_o      : count; sticks at 2^W-1 instead of wrapping
module miter_sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [W-1:0]     cnt_o
);

  // One spare bit above the wider operand so the carry is never lost.
  localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;
  localparam logic [SUM_W-1:0] MAX_VAL = (SUM_W'(1) << W) - SUM_W'(1);

  logic [W-1:0]     cnt_q, cnt_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    sum   = SUM_W'(cnt_q) + SUM_W'(inc_i);
    cnt_d = (sum > MAX_VAL) ? '1 : sum[W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/miter_cmp_monitor.sv
// Clocked gold/gate equivalence monitor for partition miters.
// Compares NUM_CH channels of WIDTH bits each, masking undefined gold bits,
// counts compared and mismatched channel-samples, latches the first failure
// and keeps a sticky fail flag.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : miter_cmp_monitor_if slave modport
//     inputs  en, clear, ch_valid, gold_data, gate_data, gold_def
//     outputs mismatch, fail, fail_ch, fail_cycle, fail_gold, fail_gate,
//             cmp_cnt, mis_cnt, busy
// The bus instance must be built with the same WIDTH/NUM_CH/CNT_W.
module miter_cmp_monitor
  import miter_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  miter_cmp_monitor_if.slave  bus
);

  localparam int IDX_W = chan_idx_w(NUM_CH);
  localparam int PC_W  = $clog2(NUM_CH + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // With no settle window a (re)start goes straight to checking.
  localparam state_e START_STATE = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;

  logic               active;
  logic [NUM_CH-1:0]  cmp_vec;
  logic [NUM_CH-1:0]  mis_vec;
  logic               any_mis;
  logic [PC_W-1:0]    cmp_inc;
  logic [PC_W-1:0]    mis_inc;
  logic [IDX_W-1:0]   first_ch;
  logic [WIDTH-1:0]   first_gold;
  logic [WIDTH-1:0]   first_gate;

  logic [CNT_W-1:0]   cyc_cnt;
  logic [CNT_W-1:0]   cmp_cnt;
  logic [CNT_W-1:0]   mis_cnt;

  logic               mismatch_q;
  logic               fail_q;
  logic [IDX_W-1:0]   fail_ch_q;
  logic [CNT_W-1:0]   fail_cycle_q;
  logic [WIDTH-1:0]   fail_gold_q;
  logic [WIDTH-1:0]   fail_gate_q;

  // ---------------------------------------------------------------------
  // Per-channel compare. A sample taken together with clear or en=0 is
  // discarded entirely.
  // ---------------------------------------------------------------------
  always_comb begin
    active     = bus.en && !bus.clear && (state_q == CHECK || state_q == FAIL);
    cmp_vec    = '0;
    mis_vec    = '0;
    cmp_inc    = '0;
    mis_inc    = '0;
    first_ch   = '0;
    first_gold = '0;
    first_gate = '0;
    // Walk downwards so the lowest mismatching channel is written last.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      cmp_vec[c] = active && bus.ch_valid[c];
      mis_vec[c] = cmp_vec[c] &&
                   |((bus.gold_data[c*WIDTH +: WIDTH] ^ bus.gate_data[c*WIDTH +: WIDTH])
                     & bus.gold_def[c*WIDTH +: WIDTH]);
      cmp_inc    = cmp_inc + PC_W'(cmp_vec[c]);
      mis_inc    = mis_inc + PC_W'(mis_vec[c]);
      if (mis_vec[c]) begin
        first_ch   = IDX_W'(c);
        first_gold = bus.gold_data[c*WIDTH +: WIDTH];
        first_gate = bus.gate_data[c*WIDTH +: WIDTH];
      end
    end
    any_mis = |mis_vec;
  end

  // ---------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    if (bus.clear) begin
      state_d = bus.en ? START_STATE : IDLE;
    end else if (!bus.en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:   state_d = START_STATE;
        SETTLE: begin
          if (int'(settle_q) >= SETTLE_CYCLES - 1) begin
            state_d = CHECK;
          end else begin
            settle_d = settle_q + SET_W'(1);
          end
        end
        CHECK:  if (any_mis) state_d = FAIL;
        FAIL:   state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // ---------------------------------------------------------------------
  // Counters: compared samples, mismatched samples, check cycles
  // ---------------------------------------------------------------------
  miter_sat_counter #(.W(CNT_W), .INC_W(PC_W)) u_cmp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (bus.clear),
    .inc_i (cmp_inc),
    .cnt_o (cmp_cnt)
  );

  miter_sat_counter #(.W(CNT_W), .INC_W(PC_W)) u_mis_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (bus.clear),
    .inc_i (mis_inc),
    .cnt_o (mis_cnt)
  );

  // Reads 0 during the first CHECK sample; the failing sample captures the
  // pre-increment value.
  miter_sat_counter #(.W(CNT_W), .INC_W(1)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (bus.clear),
    .inc_i (active),
    .cnt_o (cyc_cnt)
  );

  // ---------------------------------------------------------------------
  // Mismatch pulse, sticky fail and first-failure capture
  // ---------------------------------------------------------------------
  // NOTE: the capture registers are reset as well, because every output
  // must read 0 after reset, not just the control state.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      mismatch_q   <= 1'b0;
      fail_q       <= 1'b0;
      fail_ch_q    <= '0;
      fail_cycle_q <= '0;
      fail_gold_q  <= '0;
      fail_gate_q  <= '0;
    end else begin
      mismatch_q <= any_mis;
      if (any_mis) begin
        fail_q <= 1'b1;
      end
      // Frozen once fail is set, even across an en=0 pause.
      if (any_mis && !fail_q) begin
        fail_ch_q    <= first_ch;
        fail_cycle_q <= cyc_cnt;
        fail_gold_q  <= first_gold;
        fail_gate_q  <= first_gate;
      end
    end
  end

  assign bus.mismatch   = mismatch_q;
  assign bus.fail       = fail_q;
  assign bus.fail_ch    = fail_ch_q;
  assign bus.fail_cycle = fail_cycle_q;
  assign bus.fail_gold  = fail_gold_q;
  assign bus.fail_gate  = fail_gate_q;
  assign bus.cmp_cnt    = cmp_cnt;
  assign bus.mis_cnt    = mis_cnt;
  assign bus.busy       = (state_q != IDLE);

endmodule
